second_game_session_ctrl: RTL



---
 rtl/second_game_session_ctrl.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/second_game_session_ctrl.sv
// second_game_session_ctrl: session FSM sequencing second_game_engine through
// idle, countdown, play, pause, lose and game-over phases.
// Also keeps score, best score and lives for the overlay.
// Ports: clk, arst (async, active-high); i_button_start / i_button_pause
// (synchronized levels); i_engine_lose (engine loss pulse);
// o_engine_pause / o_engine_arst_n (engine drive); o_state, o_countdown,
// o_score, o_best_score, o_lives (overlay, all registered).
// Macro SECOND_GAME_LIVES_EN enables multi-life play; without it o_lives is 1
// and every loss ends the game.
module second_game_session_ctrl #(
   parameter int FRAME_DIV         = 262144,
   parameter int COUNT_STEP_FRAMES = 64,
   parameter int LOSE_HOLD_FRAMES  = 128,
   parameter int SCORE_FRAMES      = 60,
   parameter int LIVES             = 3,
   parameter int SCORE_W           = 16
) (
   input  logic               clk,
   input  logic               arst,
   input  logic               i_button_start,
   input  logic               i_button_pause,
   input  logic               i_engine_lose,
   output logic               o_engine_pause,
   output logic               o_engine_arst_n,
   output logic [2:0]         o_state,
   output logic [1:0]         o_countdown,
   output logic [SCORE_W-1:0] o_score,
   output logic [SCORE_W-1:0] o_best_score,
   output logic [1:0]         o_lives
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_COUNT = 3'd1,
      S_PLAY  = 3'd2,
      S_PAUSE = 3'd3,
      S_LOSE  = 3'd4,
      S_OVER  = 3'd5
   } state_t;

   localparam int CW = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
   localparam int FA = (COUNT_STEP_FRAMES > SCORE_FRAMES) ?
                       COUNT_STEP_FRAMES : SCORE_FRAMES;
   localparam int FM = (FA > LOSE_HOLD_FRAMES) ? FA : LOSE_HOLD_FRAMES;
   localparam int FW = (FM > 1) ? $clog2(FM) : 1;

   state_t             state, state_d;
   logic               start_q, pause_q;
   logic               start_rise, pause_rise;
   logic [CW-1:0]      cnt, cnt_d;
   logic [FW-1:0]      frames, frames_d;
   logic [1:0]         digit, digit_d;
   logic [SCORE_W-1:0] score, score_d;
   logic [SCORE_W-1:0] best, best_d;
   logic               eng_pause, eng_pause_d;
   logic               eng_rst_n, eng_rst_n_d;
   logic               run, tick, frame_last, step_done;
   logic               keep_phase;
   logic               lives_left;

   assign start_rise = i_button_start & ~start_q;
   assign pause_rise = i_button_pause & ~pause_q;

   // Frame counter only advances in the timed phases.
   assign run  = (state == S_COUNT) || (state == S_PLAY) ||
                 (state == S_LOSE);
   assign tick = run && (cnt == CW'(FRAME_DIV - 1));

   always_comb begin
      frame_last = 1'b0;
      case (state)
         S_COUNT: frame_last = frames == FW'(COUNT_STEP_FRAMES - 1);
         S_PLAY:  frame_last = frames == FW'(SCORE_FRAMES - 1);
         S_LOSE:  frame_last = frames == FW'(LOSE_HOLD_FRAMES - 1);
         default: frame_last = 1'b0;
      endcase
   end

   assign step_done = tick && frame_last;

`ifdef SECOND_GAME_LIVES_EN
   logic [1:0] lives, lives_d;

   always_comb begin
      lives_d = lives;
      if (state == S_IDLE ||
          (state == S_OVER && state_d == S_COUNT))
         lives_d = 2'(LIVES);
      else if (state == S_PLAY && i_engine_lose && lives != 2'd0)
         lives_d = lives - 2'd1;
   end

   always_ff @(posedge clk or posedge arst) begin
      if (arst) lives <= 2'(LIVES);
      else      lives <= lives_d;
   end

   assign lives_left = lives != 2'd0;
   assign o_lives    = lives;
`else
   assign lives_left = 1'b0;
   // Evaluates to 1 for any legal LIVES (1..3).
   assign o_lives    = 2'(LIVES != 0);
`endif

   always_comb begin
      state_d = state;
      unique case (state)
         S_IDLE:  if (start_rise) state_d = S_COUNT;
         S_COUNT: if (step_done && digit == 2'd1) state_d = S_PLAY;
         S_PLAY: begin
            if (i_engine_lose)   state_d = S_LOSE;
            else if (pause_rise) state_d = S_PAUSE;
         end
         S_PAUSE: if (pause_rise || start_rise) state_d = S_PLAY;
         S_LOSE:  if (step_done)
            state_d = lives_left ? S_COUNT : S_OVER;
         S_OVER:  if (start_rise) state_d = S_COUNT;
         default: state_d = S_IDLE;
      endcase
   end

   // PLAY<->PAUSE keeps the frame phase so a resume continues
   // exactly where the pause froze it.
   assign keep_phase = (state == S_PLAY  && state_d == S_PAUSE) ||
                       (state == S_PAUSE && state_d == S_PLAY);

   always_comb begin
      cnt_d    = cnt;
      frames_d = frames;
      if (state_d != state && !keep_phase) begin
         cnt_d    = '0;
         frames_d = '0;
      end else if (run) begin
         cnt_d = tick ? '0 : cnt + CW'(1);
         if (tick)
            frames_d = frame_last ? '0 : frames + FW'(1);
      end
   end

   always_comb begin
      digit_d = 2'd0;
      if (state_d == S_COUNT) begin
         if (state != S_COUNT) digit_d = 2'd3;
         else if (step_done)   digit_d = digit - 2'd1;
         else                  digit_d = digit;
      end
   end

   always_comb begin
      score_d = score;
      best_d  = best;
      if (state == S_IDLE)
         score_d = '0;
      else if (state == S_OVER && state_d == S_COUNT)
         score_d = '0;
      else if (state == S_PLAY && step_done && score != '1)
         score_d = score + SCORE_W'(1);
      if (state_d == S_OVER && state != S_OVER && score > best)
         best_d = score;
   end

   always_comb begin
      eng_pause_d = state_d != S_PLAY;
      eng_rst_n_d = !(state_d == S_IDLE || state_d == S_OVER) &&
                    !(state == S_LOSE && state_d == S_COUNT);
   end

   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         state     <= S_IDLE;
         start_q   <= 1'b1;
         pause_q   <= 1'b1;
         cnt       <= '0;
         frames    <= '0;
         digit     <= 2'd0;
         score     <= '0;
         best      <= '0;
         eng_pause <= 1'b1;
         eng_rst_n <= 1'b0;
      end else begin
         state     <= state_d;
         start_q   <= i_button_start;
         pause_q   <= i_button_pause;
         cnt       <= cnt_d;
         frames    <= frames_d;
         digit     <= digit_d;
         score     <= score_d;
         best      <= best_d;
         eng_pause <= eng_pause_d;
         eng_rst_n <= eng_rst_n_d;
      end
   end

   assign o_state         = state;
   assign o_countdown     = digit;
   assign o_score         = score;
   assign o_best_score    = best;
   assign o_engine_pause  = eng_pause;
   assign o_engine_arst_n = eng_rst_n;

endmodule
